adder_word_loader: RTL

- Front-end loader for the 16-operand adder.
- Accepts 25-bit operands one per cycle over a valid/ready stream and packs them into a 16-slot operand bank.
- Presents the full bank in parallel (slot k drives the adder's WORD_k) with a valid/ack handshake.
- Is the writer/producer side of the adder's parallel operand interface.

---
 rtl/adder_word_loader.sv | 93 +++++++++
 1 files changed

// File: rtl/adder_word_loader.sv
// adder_word_loader: front-end loader for the 16-operand adder.
// Accepts WIDTH-bit operands one per cycle over a valid/ready stream and
// packs them into a DEPTH-slot bank. The full bank is then presented in
// parallel, with a valid/ack handshake, to the adder's operand interface.
//
// Ports:
//   CLK         system clock, all logic on posedge
//   RST         synchronous active-high reset
//   IN_DATA     serial operand word
//   IN_VALID    IN_DATA valid
//   IN_READY    loader can accept a word this cycle
//   FLUSH       discard a partial fill (or release a held bank), restart at slot 0
//   WORDS       packed bank, slot k at [k*WIDTH +: WIDTH]
//   WORDS_VALID bank is complete and stable
//   WORDS_ACK   consumer has captured WORDS
//   COUNT       number of slots filled so far (0..DEPTH)
module adder_word_loader #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   FLUSH,
  output logic [WIDTH*DEPTH-1:0] WORDS,
  output logic                   WORDS_VALID,
  input  logic                   WORDS_ACK,
  output logic [CW-1:0]          COUNT
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] slots [DEPTH];
  logic             wr_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FILL;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      // Only the slot addressed by the current fill count changes.
      if (wr_en) slots[count[IW-1:0]] <= IN_DATA;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    wr_en       = 1'b0;
    IN_READY    = 1'b0;
    WORDS_VALID = 1'b0;
    case (state)
      FILL: begin
        // Not ready while reset is being applied.
        IN_READY = ~RST;
        if (FLUSH) begin
          // Flush beats a simultaneous accept; that word is dropped.
          count_n = '0;
        end else if (IN_VALID && IN_READY) begin
          wr_en   = 1'b1;
          count_n = count + CW'(1);
          if (count == CW'(DEPTH - 1)) state_n = HOLD;
        end
      end
      HOLD: begin
        WORDS_VALID = 1'b1;
        if (WORDS_ACK || FLUSH) begin
          count_n = '0;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_comb begin
    WORDS = '0;
    for (int unsigned i = 0; i < DEPTH; i++) WORDS[i*WIDTH +: WIDTH] = slots[i];
  end

  assign COUNT = count;

endmodule
